// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
// Fetch-stage program-counter unit for the 64-bit pipelined ARM core.
// Selects the next fetch address: sequential, PC-relative branch, or register target.
// Drives the fetch address and the IF/ID pipeline register.
// Handles stall, redirect squash, optional post-redirect bubble cycles and halt.
// Optional feature macro: PC_MISALIGN_TRAP_EN. When defined, a redirect to a
// non-word-aligned target halts the unit and raises the sticky 'misalign' output.

module pc_redirect_unit #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int unsigned FLUSH_CYCLES = 0      // bubbles after a redirect, 0..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_pc,
  input  logic [63:0] br_offset_sh,
  input  logic        br_reg,
  input  logic [63:0] br_reg_target,
  input  logic        halt,
  output logic [63:0] pc,
  output logic [63:0] if_id_pc,
  output logic [63:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        squash,
`ifdef PC_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t      state;
  logic [3:0]  flush_cnt;
  logic [63:0] br_target;
  logic [63:0] pc_plus4;
  logic        target_misaligned;

  // Branch target and sequential successor; plain modulo-2^64 adds.
  always_comb begin
    br_target = br_reg ? br_reg_target : (br_pc + br_offset_sh);
    pc_plus4  = pc + 64'd4;
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign target_misaligned = |br_target[1:0];
`else
  assign target_misaligned = 1'b0;
`endif

  // PC, IF/ID register and the RUN/FLUSH/HALT state machine, all registered.
  // NOTE: every register here is updated with non-blocking assignments so that
  // reads of pc/state within this block see the pre-edge value, as hardware does.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: reset is synchronous and overrides every other input in every state;
      // all state, including the IF/ID payload, gets a defined value.
      state          <= ST_RUN;
      flush_cnt      <= 4'd0;
      pc             <= RESET_PC;
      if_id_pc       <= 64'd0;
      if_id_pc_plus4 <= 64'd0;
      if_id_valid    <= 1'b0;
      squash         <= 1'b0;
      halted         <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RUN, ST_FLUSH: begin
          if (br_taken) begin
            if_id_valid <= 1'b0;
            if (target_misaligned) begin
              // Trap: the bad target is never fetched; pc keeps its old value.
              squash <= 1'b0;
              halted <= 1'b1;
              state  <= ST_HALT;
`ifdef PC_MISALIGN_TRAP_EN
              misalign <= 1'b1;
`endif
            end else begin
              // Redirect wins over halt and stall; (re)start the bubble window.
              pc     <= br_target;
              squash <= 1'b1;
              if (FLUSH_CYCLES > 0) begin
                state     <= ST_FLUSH;
                flush_cnt <= FLUSH_LOAD;
              end else begin
                state <= ST_RUN;
              end
            end
          end else if (halt) begin
            state       <= ST_HALT;
            halted      <= 1'b1;
            if_id_valid <= 1'b0;
            squash      <= 1'b0;
          end else if (state == ST_FLUSH) begin
            // Bubble cycle: pc held; stall freezes the countdown.
            if_id_valid <= 1'b0;
            squash      <= 1'b0;
            if (!stall) begin
              flush_cnt <= flush_cnt - 4'd1;
              if (flush_cnt <= 4'd1) begin
                state <= ST_RUN;
              end
            end
          end else if (stall) begin
            squash <= 1'b0;
          end else begin
            pc             <= pc_plus4;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
            squash         <= 1'b0;
          end
        end

        ST_HALT: begin
          // Only reset leaves HALT; pc and IF/ID payload stay frozen.
          if_id_valid <= 1'b0;
          squash      <= 1'b0;
          halted      <= 1'b1;
        end

        default: begin
          state       <= ST_HALT;
          halted      <= 1'b1;
          if_id_valid <= 1'b0;
          squash      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Testbench for pc_redirect_unit.
// dut0: RESET_PC=0, FLUSH_CYCLES=0 (table-driven vectors).
// dut2: RESET_PC=0x1000, FLUSH_CYCLES=2 (hand-written bubble sequences).

module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, br_reg, halt;
  logic [63:0] br_pc, br_offset_sh, br_reg_target;

  logic [63:0] pc0, ifpc0, ifp40, pc2, ifpc2, ifp42;
  logic        v0, sq0, h0, v2, sq2, h2;
`ifdef PC_MISALIGN_TRAP_EN
  logic        mis0, mis2;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(.RESET_PC(64'h0), .FLUSH_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_pc(br_pc), .br_offset_sh(br_offset_sh), .br_reg(br_reg),
    .br_reg_target(br_reg_target), .halt(halt),
    .pc(pc0), .if_id_pc(ifpc0), .if_id_pc_plus4(ifp40),
    .if_id_valid(v0), .squash(sq0),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign(mis0),
`endif
    .halted(h0)
  );

  pc_redirect_unit #(.RESET_PC(64'h1000), .FLUSH_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_pc(br_pc), .br_offset_sh(br_offset_sh), .br_reg(br_reg),
    .br_reg_target(br_reg_target), .halt(halt),
    .pc(pc2), .if_id_pc(ifpc2), .if_id_pc_plus4(ifp42),
    .if_id_valid(v2), .squash(sq2),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign(mis2),
`endif
    .halted(h2)
  );

  typedef struct {
    logic        rst, stl, br, brr, hlt;
    logic [63:0] bpc, boff, btgt;
    logic [63:0] e_pc, e_ifpc, e_ifp4;
    logic        e_v, e_sq, e_h;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic void add(input logic rst, stl, br, brr, hlt,
                              input logic [63:0] bpc, boff, btgt,
                              input logic [63:0] e_pc, e_ifpc, e_ifp4,
                              input logic e_v, e_sq, e_h);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.brr = brr; v.hlt = hlt;
    v.bpc = bpc; v.boff = boff; v.btgt = btgt;
    v.e_pc = e_pc; v.e_ifpc = e_ifpc; v.e_ifp4 = e_ifp4;
    v.e_v = e_v; v.e_sq = e_sq; v.e_h = e_h;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs away from the edge, then let the edge happen.
  task automatic step(input logic rst, stl, br, brr, hlt, input logic [63:0] bpc, boff, btgt);
    @(negedge clk);
    reset = rst; stall = stl; br_taken = br; br_reg = brr; halt = hlt;
    br_pc = bpc; br_offset_sh = boff; br_reg_target = btgt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk2(input string tag, input logic [63:0] e_pc, input logic e_v,
                      input logic e_sq, input logic e_h);
    check({tag, ".pc"}, pc2, e_pc);
    check({tag, ".valid"}, 64'(v2), 64'(e_v));
    check({tag, ".squash"}, 64'(sq2), 64'(e_sq));
    check({tag, ".halted"}, 64'(h2), 64'(e_h));
  endtask

  localparam logic [63:0] NEG16 = 64'hFFFF_FFFF_FFFF_FFF0;
  localparam logic [63:0] TOPM8 = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] TOPM4 = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_reg = 1'b0; halt = 1'b0;
    br_pc = '0; br_offset_sh = '0; br_reg_target = '0;

    //   rst stl br brr hlt  br_pc   br_off  br_tgt     pc       ifpc    ifp4     v sq h
    add(1, 0, 0, 0, 0, 64'h0,  64'h0,  64'h0,     64'h0,   64'h0,   64'h0,   0, 0, 0);
    add(0, 0, 0, 0, 0, 64'h0,  64'h0,  64'h0,     64'h4,   64'h0,   64'h4,   1, 0, 0);
    add(0, 0, 0, 0, 0, 64'h0,  64'h0,  64'h0,     64'h8,   64'h4,   64'h8,   1, 0, 0);
    add(0, 0, 0, 0, 0, 64'h0,  64'h0,  64'h0,     64'hC,   64'h8,   64'hC,   1, 0, 0);
    add(0, 0, 1, 0, 0, 64'h20, NEG16,  64'h0,     64'h10,  64'h8,   64'hC,   0, 1, 0);
    add(0, 0, 0, 0, 0, 64'h0,  64'h0,  64'h0,     64'h14,  64'h10,  64'h14,  1, 0, 0);
    add(0, 1, 1, 1, 0, 64'h0,  64'h0,  64'h100,   64'h100, 64'h10,  64'h14,  0, 1, 0);
    add(0, 1, 0, 0, 0, 64'h0,  64'h0,  64'h0,     64'h100, 64'h10,  64'h14,  0, 0, 0);
    add(0, 0, 0, 0, 0, 64'h0,  64'h0,  64'h0,     64'h104, 64'h100, 64'h104, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 0, 0, 64'h0, 64'h0, 64'h0,     64'h104, 64'h100, 64'h104, 1, 0, 0);
    add(0, 0, 0, 0, 0, 64'h0,  64'h0,  64'h0,     64'h108, 64'h104, 64'h108, 1, 0, 0);
    add(0, 0, 1, 1, 0, 64'h0,  64'h0,  TOPM8,     TOPM8,   64'h104, 64'h108, 0, 1, 0);
    add(0, 0, 0, 0, 0, 64'h0,  64'h0,  64'h0,     TOPM4,   TOPM8,   TOPM4,   1, 0, 0);
    add(0, 0, 0, 0, 0, 64'h0,  64'h0,  64'h0,     64'h0,   TOPM4,   64'h0,   1, 0, 0);
    add(0, 0, 0, 0, 1, 64'h0,  64'h0,  64'h0,     64'h0,   TOPM4,   64'h0,   0, 0, 1);
    add(0, 0, 1, 1, 0, 64'h0,  64'h0,  64'h200,   64'h0,   TOPM4,   64'h0,   0, 0, 1);
    add(0, 1, 0, 0, 1, 64'h0,  64'h0,  64'h0,     64'h0,   TOPM4,   64'h0,   0, 0, 1);
    add(1, 0, 1, 1, 0, 64'h0,  64'h0,  64'h300,   64'h0,   64'h0,   64'h0,   0, 0, 0);
    add(0, 0, 0, 0, 0, 64'h0,  64'h0,  64'h0,     64'h4,   64'h0,   64'h4,   1, 0, 0);
    add(0, 1, 0, 0, 1, 64'h0,  64'h0,  64'h0,     64'h4,   64'h0,   64'h4,   0, 0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].brr, vecs[i].hlt,
           vecs[i].bpc, vecs[i].boff, vecs[i].btgt);
      check($sformatf("v%0d.pc", i), pc0, vecs[i].e_pc);
      check($sformatf("v%0d.if_id_pc", i), ifpc0, vecs[i].e_ifpc);
      check($sformatf("v%0d.if_id_pc_plus4", i), ifp40, vecs[i].e_ifp4);
      check($sformatf("v%0d.valid", i), 64'(v0), 64'(vecs[i].e_v));
      check($sformatf("v%0d.squash", i), 64'(sq0), 64'(vecs[i].e_sq));
      check($sformatf("v%0d.halted", i), 64'(h0), 64'(vecs[i].e_h));
    end

    // FLUSH_CYCLES=2: BR to 0x400, one stall inside the bubble window.
    step(1, 0, 0, 0, 0, 0, 0, 0);            chk2("f.reset", 64'h1000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);            chk2("f.seq",   64'h1004, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 64'h400);      chk2("f.redir", 64'h400, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);            chk2("f.bub1",  64'h400, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);            chk2("f.bub2s", 64'h400, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);            chk2("f.bub3",  64'h400, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);            chk2("f.run",   64'h404, 1, 0, 0);
    check("f.run.if_id_pc", ifpc2, 64'h400);
    check("f.run.if_id_pc_plus4", ifp42, 64'h404);

    // Redirect inside FLUSH reloads the counter.
    step(0, 0, 1, 1, 0, 0, 0, 64'h800);      chk2("r.redir1", 64'h800, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);            chk2("r.bub",    64'h800, 0, 0, 0);
    step(0, 0, 1, 0, 0, 64'h880, 64'h80, 0); chk2("r.redir2", 64'h900, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);            chk2("r.bub1",   64'h900, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);            chk2("r.bub2",   64'h900, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);            chk2("r.run",    64'h904, 1, 0, 0);

    // Halt during FLUSH goes to HALT and stays there.
    step(0, 0, 1, 1, 0, 0, 0, 64'hA00);      chk2("h.redir", 64'hA00, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);            chk2("h.halt",  64'hA00, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);            chk2("h.stay",  64'hA00, 0, 0, 1);
    step(0, 0, 1, 1, 0, 0, 0, 64'hB00);      chk2("h.ignbr", 64'hA00, 0, 0, 1);

    // Misaligned register target on dut0.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 64'h402);
`ifdef PC_MISALIGN_TRAP_EN
    check("m.pc", pc0, 64'h0);
    check("m.halted", 64'(h0), 64'd1);
    check("m.misalign", 64'(mis0), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("m.sticky", 64'(mis0), 64'd1);
    check("m.pc_hold", pc0, 64'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("m.reset", 64'(mis0), 64'd0);
`else
    check("m.pc", pc0, 64'h402);
    check("m.halted", 64'(h0), 64'd0);
    check("m.squash", 64'(sq0), 64'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Fetch-stage program-counter unit of the 64-bit pipelined ARM core.
- Consumes the word-aligned (already left-shifted by 2) branch offset and the PC of the resolving branch.
- Computes the branch target, selects the next PC (sequential, branch, or register target), and drives the fetch address plus the IF/ID pipeline register.
- Handles stall, redirect squash, optional post-redirect bubbles, and halt.

Parameters:
- RESET_PC, 64'h0, fetch address loaded on reset.
- FLUSH_CYCLES, 0, extra bubble cycles inserted after a redirect (range 0-15), for multi-cycle imem.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall from ID; holds PC and IF/ID.
- br_taken  input  1  branch resolved taken this cycle (B, CBZ, B.cond, BL).
- br_pc  input  64  PC of the resolving branch instruction.
- br_offset_sh  input  64  sign-extended offset, already shifted left by 2.
- br_reg  input  1  with br_taken: register-target branch (BR); use br_reg_target.
- br_reg_target  input  64  register-target address.
- halt  input  1  end-of-program indication.
- pc  output  64  current fetch address to instruction memory.
- if_id_pc  output  64  PC of the instruction in IF/ID.
- if_id_pc_plus4  output  64  link value for BL.
- if_id_valid  output  1  IF/ID holds a real instruction.
- squash  output  1  registered one-cycle pulse: a redirect occurred on the previous edge.
- halted  output  1  unit is in HALT.

Behaviour:
- Target: br_target = br_reg ? br_reg_target : br_pc + br_offset_sh. 64-bit, modulo 2^64, no overflow flag. Sequential next = pc + 4, wraps 64'hFFFF_FFFF_FFFF_FFFC -> 0.
- Reset (reset=1 at edge):
  - pc=RESET_PC; if_id_pc=0; if_id_pc_plus4=0; if_id_valid=0; squash=0; halted=0.
  - State RUN, bubble counter 0.
  - Reset overrides all other inputs, including mid-FLUSH or HALT.
- States are RUN, FLUSH and HALT. Priority within a state is reset > br_taken > halt > stall > normal.
- RUN:
  - br_taken: pc<=br_target; if_id_valid<=0; squash<=1. Next state is FLUSH with counter<=FLUSH_CYCLES if FLUSH_CYCLES>0, else RUN. stall is ignored; redirect wins.
  - halt: pc held; if_id_valid<=0; state<=HALT; halted<=1.
  - stall: pc, if_id_pc, if_id_pc_plus4 and if_id_valid all held.
  - normal: pc<=pc+4; if_id_pc<=pc; if_id_pc_plus4<=pc+4; if_id_valid<=1.
- FLUSH:
  - pc held; if_id_valid<=0; squash<=0.
  - Without stall: counter decrements; when counter==1 at the edge, state<=RUN.
  - stall freezes the counter.
  - br_taken in FLUSH is honoured: pc<=br_target, counter reloaded, squash<=1.
  - halt in FLUSH: goes to HALT.
- HALT:
  - pc and IF/ID held; if_id_valid=0; halted=1.
  - br_taken, stall and halt are ignored. Exit is by reset only.
- squash is 0 in every cycle not immediately following a redirect edge.
- Latency: pc update is 1 cycle after the qualifying input. IF/ID reflects the fetched pc 1 cycle later.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect whose br_target[1:0]!=2'b00 does not load pc. It enters HALT with halted=1, and pc keeps its old value.
  - Adds output misalign (1 bit), reset 0, set on that edge and sticky until reset.
- Undefined:
  - No misalign port. br_target is loaded as-is.
  - Only br_reg can produce a misaligned target, since br_offset_sh[1:0] is always 0.

Test Plan:
- Reset then 3 free cycles, RESET_PC=0 -> pc 0,4,8,12; if_id_pc 0,4,8 with if_id_valid=1 from the second edge; if_id_pc_plus4 4,8,12.
- Branch: br_taken=1, br_pc=0x20, br_offset_sh=0xFFFF_FFFF_FFFF_FFF0 -> next pc=0x10, if_id_valid=0, squash=1 for exactly one cycle, then sequential fetch resumes at 0x14.
- FLUSH_CYCLES=2, br_reg=1, br_reg_target=0x400, stall asserted 1 cycle during FLUSH -> pc=0x400 held for 3 bubble cycles with if_id_valid=0, then RUN fetches 0x404.
- Simultaneous br_taken and stall -> redirect taken. Stall alone for 4 cycles -> pc and if_id_* unchanged throughout.
- Wrap: pc=0xFFFF_FFFF_FFFF_FFFC, one free cycle -> pc=0. Then halt=1 -> halted=1, pc frozen; later br_taken ignored; reset -> pc=RESET_PC, halted=0.
- With PC_MISALIGN_TRAP_EN: BR to 0x402 -> misalign=1, halted=1, pc unchanged. Without the macro: pc=0x402.
